// File: rtl/fpu_pkg.sv
// ============================================================================
// Module  : fpu_pkg
// Brief   : Shared bit indices, defaults and interrupt FSM encoding for the
//           FPU control/status register block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

  // Status word bit positions
  localparam int IE      = 0;
  localparam int DE      = 1;
  localparam int ZE      = 2;
  localparam int OE      = 3;
  localparam int UE      = 4;
  localparam int PE      = 5;
  localparam int SF      = 6;
  localparam int ES      = 7;
  localparam int C0      = 8;
  localparam int C1      = 9;
  localparam int C2      = 10;
  localparam int TOP_LSB = 11;
  localparam int TOP_MSB = 13;
  localparam int C3      = 14;
  localparam int B       = 15;

  // Control word bit positions
  localparam int IEM     = 7;
  localparam int PC_LSB  = 8;
  localparam int PC_MSB  = 9;
  localparam int RC_LSB  = 10;
  localparam int RC_MSB  = 11;
  localparam int IC      = 12;

  localparam logic [15:0] CW_DEFAULT = 16'h037F;
  localparam logic [15:0] SW_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PENDING = 2'd1,
    IRQ_ACKED   = 2'd2
  } irq_state_t;

endpackage

`default_nettype wire

// File: rtl/fpu_irq_fsm.sv
// ============================================================================
// Module  : fpu_irq_fsm
// Brief   : One-request-per-episode interrupt handshake (IDLE/PENDING/ACKED).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_irq_fsm
  import fpu_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic irq_en,
  input  logic int_ack,
  output logic int_req
);

  irq_state_t r_state;
  irq_state_t w_state_next;
  logic       r_int_req;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IRQ_IDLE;
      r_int_req <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_int_req <= (w_state_next == IRQ_PENDING);
    end
  end

  // ACKED only leaves once the exception episode ends, so no re-request.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IRQ_IDLE: begin
        if (irq_en) w_state_next = IRQ_PENDING;
      end
      IRQ_PENDING: begin
        if (!irq_en)      w_state_next = IRQ_IDLE;
        else if (int_ack) w_state_next = IRQ_ACKED;
      end
      IRQ_ACKED: begin
        if (!irq_en) w_state_next = IRQ_IDLE;
      end
      default: w_state_next = IRQ_IDLE;
    endcase
  end

  assign int_req = r_int_req;

endmodule

`default_nettype wire

// File: rtl/fpu_control_status_regs.sv
// ============================================================================
// Module  : fpu_control_status_regs
// Brief   : 8087 control word / status word registers with sticky exceptions,
//           TOP pointer, condition codes and interrupt request generation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_control_status_regs
  import fpu_pkg::*;
#(
  parameter logic [15:0] CW_RESET   = CW_DEFAULT,
  parameter logic [15:0] CW_WMASK   = 16'h1FBF,
  parameter logic [15:0] SW_RESET   = SW_DEFAULT,
  parameter bit          IEM_ENABLE = 1'b1,
  parameter bit          SF_ENABLE  = 1'b1
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cw_we,
  input  logic [1:0]  cw_be,
  input  logic [15:0] cw_wdata,
  input  logic        sw_we,
  input  logic [15:0] sw_wdata,
  input  logic        fclex,
  input  logic        finit,
  input  logic        exc_valid,
  input  logic [6:0]  exc_flags,
  input  logic        cc_we,
  input  logic [3:0]  cc_wdata,
  input  logic        top_inc,
  input  logic        top_dec,
  input  logic        int_ack,
  output logic [15:0] control_word,
  output logic [15:0] status_word,
  output logic [5:0]  exception_masks,
  output logic [1:0]  rounding_control,
  output logic [1:0]  precision_control,
  output logic        infinity_control,
  output logic [2:0]  top,
  output logic        int_req
);

  localparam logic [6:0] c_flag_mask = SF_ENABLE ? 7'h7F : 7'h3F;
  localparam logic [6:0] c_flags_rst = SW_RESET[6:0] & c_flag_mask;
  localparam logic [3:0] c_cc_rst    = {SW_RESET[C3], SW_RESET[C2:C0]};
  localparam logic [2:0] c_top_rst   = SW_RESET[TOP_MSB:TOP_LSB];
  localparam logic       c_es_rst    = (|(c_flags_rst[5:0] & ~CW_RESET[5:0])) | c_flags_rst[SF];

  logic [15:0] r_cw;
  logic [6:0]  r_flags;
  logic [3:0]  r_cc;     // {C3,C2,C1,C0}
  logic [2:0]  r_top;
  logic        r_es;

  logic [15:0] w_cw_written;
  logic [15:0] w_cw_next;
  logic [6:0]  w_flags_next;
  logic [3:0]  w_cc_next;
  logic [2:0]  w_top_next;
  logic        w_es_next;
  logic        w_irq_en;

  // Non-writable bits of an enabled byte are forced back to their reset value.
  for (genvar b = 0; b < 2; b++) begin : g_cw_byte
    assign w_cw_written[8*b +: 8] = cw_be[b]
      ? ((cw_wdata[8*b +: 8] & CW_WMASK[8*b +: 8]) | (CW_RESET[8*b +: 8] & ~CW_WMASK[8*b +: 8]))
      : r_cw[8*b +: 8];
  end

  always_comb begin
    w_cw_next    = r_cw;
    w_flags_next = r_flags;
    w_cc_next    = r_cc;
    w_top_next   = r_top;
    if (finit) begin
      w_cw_next    = CW_RESET;
      w_flags_next = c_flags_rst;
      w_cc_next    = c_cc_rst;
      w_top_next   = c_top_rst;
    end else begin
      if (cw_we) w_cw_next = w_cw_written;
      if (sw_we) begin
        w_flags_next = sw_wdata[6:0] & c_flag_mask;
        w_cc_next    = {sw_wdata[C3], sw_wdata[C2:C0]};
        w_top_next   = sw_wdata[TOP_MSB:TOP_LSB];
      end else begin
        // Clear first so exceptions reported alongside fclex survive.
        if (fclex)     w_flags_next = 7'h00;
        if (exc_valid) w_flags_next = w_flags_next | (exc_flags & c_flag_mask);
        if (cc_we)     w_cc_next = cc_wdata;
        if (top_inc && !top_dec)      w_top_next = r_top + 3'd1;
        else if (top_dec && !top_inc) w_top_next = r_top - 3'd1;
      end
    end
    w_es_next = (|(w_flags_next[5:0] & ~w_cw_next[5:0])) | w_flags_next[SF];
  end

  if (IEM_ENABLE) begin : g_iem
    assign w_irq_en = w_es_next & ~w_cw_next[IEM];
  end else begin : g_no_iem
    assign w_irq_en = w_es_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cw    <= CW_RESET;
      r_flags <= c_flags_rst;
      r_cc    <= c_cc_rst;
      r_top   <= c_top_rst;
      r_es    <= c_es_rst;
    end else begin
      r_cw    <= w_cw_next;
      r_flags <= w_flags_next;
      r_cc    <= w_cc_next;
      r_top   <= w_top_next;
      r_es    <= w_es_next;
    end
  end

  fpu_irq_fsm u_irq_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_en  (w_irq_en),
    .int_ack (int_ack),
    .int_req (int_req)
  );

  assign control_word      = r_cw;
  assign status_word       = {r_es, r_cc[3], r_top, r_cc[2:0], r_es, r_flags};
  assign exception_masks   = r_cw[5:0];
  assign rounding_control  = r_cw[RC_MSB:RC_LSB];
  assign precision_control = r_cw[PC_MSB:PC_LSB];
  assign infinity_control  = r_cw[IC];
  assign top               = r_top;

endmodule

`default_nettype wire

// File: tb/tb_fpu_control_status_regs.sv
// ============================================================================
// Module  : tb_fpu_control_status_regs
// Brief   : Vector-table bench with expected-result scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpu_control_status_regs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cw_we;
  logic [1:0]  cw_be;
  logic [15:0] cw_wdata;
  logic        sw_we;
  logic [15:0] sw_wdata;
  logic        fclex;
  logic        finit;
  logic        exc_valid;
  logic [6:0]  exc_flags;
  logic        cc_we;
  logic [3:0]  cc_wdata;
  logic        top_inc;
  logic        top_dec;
  logic        int_ack;
  logic [15:0] control_word;
  logic [15:0] status_word;
  logic [5:0]  exception_masks;
  logic [1:0]  rounding_control;
  logic [1:0]  precision_control;
  logic        infinity_control;
  logic [2:0]  top;
  logic        int_req;

  always #5 clk = ~clk;

  fpu_control_status_regs dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cw_we             (cw_we),
    .cw_be             (cw_be),
    .cw_wdata          (cw_wdata),
    .sw_we             (sw_we),
    .sw_wdata          (sw_wdata),
    .fclex             (fclex),
    .finit             (finit),
    .exc_valid         (exc_valid),
    .exc_flags         (exc_flags),
    .cc_we             (cc_we),
    .cc_wdata          (cc_wdata),
    .top_inc           (top_inc),
    .top_dec           (top_dec),
    .int_ack           (int_ack),
    .control_word      (control_word),
    .status_word       (status_word),
    .exception_masks   (exception_masks),
    .rounding_control  (rounding_control),
    .precision_control (precision_control),
    .infinity_control  (infinity_control),
    .top               (top),
    .int_req           (int_req)
  );

  typedef struct {
    logic        rst_n;
    logic        cw_we;
    logic [1:0]  cw_be;
    logic [15:0] cw_wd;
    logic        sw_we;
    logic [15:0] sw_wd;
    logic        fclex;
    logic        finit;
    logic        exc_v;
    logic [6:0]  exc_f;
    logic        cc_we;
    logic [3:0]  cc_wd;
    logic        tinc;
    logic        tdec;
    logic        ack;
    logic [15:0] exp_cw;
    logic [15:0] exp_sw;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] cw;
    logic [15:0] sw;
    logic        irq;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t v(input logic rst_n, input logic cwe, input logic [1:0] be,
                             input logic [15:0] cwd, input logic swe, input logic [15:0] swd,
                             input logic fcl, input logic fin, input logic ev, input logic [6:0] ef,
                             input logic cce, input logic [3:0] ccd, input logic ti, input logic td,
                             input logic ak, input logic [15:0] ecw, input logic [15:0] esw,
                             input logic eirq);
    vec_t r;
    r.rst_n = rst_n; r.cw_we = cwe; r.cw_be = be; r.cw_wd = cwd;
    r.sw_we = swe; r.sw_wd = swd; r.fclex = fcl; r.finit = fin;
    r.exc_v = ev; r.exc_f = ef; r.cc_we = cce; r.cc_wd = ccd;
    r.tinc = ti; r.tdec = td; r.ack = ak;
    r.exp_cw = ecw; r.exp_sw = esw; r.exp_irq = eirq;
    return r;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic apply(input vec_t t, input int idx);
    exp_t e;
    @(negedge clk);
    reset_n = t.rst_n; cw_we = t.cw_we; cw_be = t.cw_be; cw_wdata = t.cw_wd;
    sw_we = t.sw_we; sw_wdata = t.sw_wd; fclex = t.fclex; finit = t.finit;
    exc_valid = t.exc_v; exc_flags = t.exc_f; cc_we = t.cc_we; cc_wdata = t.cc_wd;
    top_inc = t.tinc; top_dec = t.tdec; int_ack = t.ack;
    e.idx = idx; e.cw = t.exp_cw; e.sw = t.exp_sw; e.irq = t.exp_irq;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("control_word", e.idx, {16'h0, control_word}, {16'h0, e.cw});
    check("status_word",  e.idx, {16'h0, status_word},  {16'h0, e.sw});
    check("int_req",      e.idx, {31'h0, int_req},      {31'h0, e.irq});
    // Derived fields re-extracted from the expected register images
    check("derived", e.idx,
          {16'h0, exception_masks, rounding_control, precision_control, infinity_control, top},
          {16'h0, e.cw[5:0], e.cw[11:10], e.cw[9:8], e.cw[12], e.sw[13:11]});
  endtask

  initial begin
    reset_n = 1'b0; cw_we = 1'b0; cw_be = 2'b00; cw_wdata = 16'h0;
    sw_we = 1'b0; sw_wdata = 16'h0; fclex = 1'b0; finit = 1'b0;
    exc_valid = 1'b0; exc_flags = 7'h0; cc_we = 1'b0; cc_wdata = 4'h0;
    top_inc = 1'b0; top_dec = 1'b0; int_ack = 1'b0;

    //               rst cwe be     cwd       swe swd      fcl fin ev ef     cce ccd   ti td ak  exp_cw    exp_sw    irq
    vecs.push_back(v(0, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h0000, 0)); // 0 reset
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h0000, 0)); // 1 idle
    vecs.push_back(v(1, 1, 2'b01, 16'hFF7E, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037E, 16'h0000, 0)); // 2 low byte
    vecs.push_back(v(1, 1, 2'b10, 16'hFFFF, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h1F7E, 16'h0000, 0)); // 3 high byte
    vecs.push_back(v(1, 1, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h1F7E, 16'h0000, 0)); // 4 be=00
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 1, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h0000, 0)); // 5 finit
    vecs.push_back(v(1, 1, 2'b11, 16'h037B, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037B, 16'h0000, 0)); // 6 unmask ZE
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 1, 7'h04, 0, 4'h0, 0, 0, 0, 16'h037B, 16'h8084, 1)); // 7 ZE
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037B, 16'h8084, 1)); // 8 hold
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 1, 16'h037B, 16'h8084, 0)); // 9 ack
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 1, 7'h04, 0, 4'h0, 0, 0, 0, 16'h037B, 16'h8084, 0)); // 10 no re-req
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 1, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037B, 16'h0000, 0)); // 11 fclex
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 1, 7'h04, 0, 4'h0, 0, 0, 0, 16'h037B, 16'h8084, 1)); // 12 second ZE
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 1, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h0000, 0)); // 13 finit
    vecs.push_back(v(1, 1, 2'b11, 16'h037E, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037E, 16'h0000, 0)); // 14 unmask IE
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 1, 0, 1, 7'h01, 0, 4'h0, 0, 0, 0, 16'h037E, 16'h8081, 1)); // 15 fclex+exc
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 1, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037E, 16'h0000, 0)); // 16 fclex
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 1, 7'h01, 0, 4'h0, 0, 0, 0, 16'h037E, 16'h8081, 1)); // 17 IE
    vecs.push_back(v(1, 1, 2'b11, 16'h037F, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h0001, 0)); // 18 mask drops ES
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 1, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h0000, 0)); // 19 fclex
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 1, 0, 16'h037F, 16'h3800, 0)); // 20 dec 0->7
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 1, 1, 0, 16'h037F, 16'h3800, 0)); // 21 inc+dec
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 1, 0, 0, 16'h037F, 16'h0000, 0)); // 22 inc 7->0
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00, 1, 4'hF, 0, 0, 0, 16'h037F, 16'h4700, 0)); // 23 cc
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 1, 7'h02, 1, 4'h0, 0, 1, 0, 16'h037F, 16'h3802, 0)); // 24 cc+top+exc
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 1, 16'hFFFF, 0, 0, 0, 7'h00, 0, 4'h0, 1, 0, 0, 16'h037F, 16'hFFFF, 1)); // 25 sw load
    vecs.push_back(v(0, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h0000, 0)); // 26 reset mid-req
    vecs.push_back(v(1, 1, 2'b11, 16'h03FB, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h03FB, 16'h0000, 0)); // 27 IEM=1
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 0, 1, 7'h04, 0, 4'h0, 0, 0, 0, 16'h03FB, 16'h8084, 0)); // 28 ES, gated
    vecs.push_back(v(1, 1, 2'b11, 16'h037B, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037B, 16'h8084, 1)); // 29 IEM cleared
    vecs.push_back(v(1, 1, 2'b11, 16'h0000, 0, 16'h0000, 0, 1, 1, 7'h04, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h0000, 0)); // 30 finit wins
    vecs.push_back(v(1, 0, 2'b00, 16'h0000, 1, 16'h0041, 0, 0, 1, 7'h04, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h80C1, 1)); // 31 sw_we wins

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Request stays up without an acknowledge, then one ack ends it.
    for (int i = 0; i < 3; i++)
      apply(v(1, 0, 2'b00, 16'h0, 0, 16'h0, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h80C1, 1), 100 + i);
    apply(v(1, 0, 2'b00, 16'h0, 0, 16'h0, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 1, 16'h037F, 16'h80C1, 0), 103);
    apply(v(1, 0, 2'b00, 16'h0, 0, 16'h0, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 1, 16'h037F, 16'h80C1, 0), 104);
    apply(v(1, 0, 2'b00, 16'h0, 0, 16'h0, 1, 0, 0, 7'h00, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h0000, 0), 105);
    // Ack while idle is ignored; a fresh exception still requests.
    apply(v(1, 0, 2'b00, 16'h0, 0, 16'h0, 0, 0, 0, 7'h00, 0, 4'h0, 0, 0, 1, 16'h037F, 16'h0000, 0), 106);
    apply(v(1, 0, 2'b00, 16'h0, 0, 16'h0, 0, 0, 1, 7'h40, 0, 4'h0, 0, 0, 0, 16'h037F, 16'h80C0, 1), 107);

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
